seven_seg_scanner: RTL and testbench

//  Parametrised multiplexed 7-seg driver, successor of the fixed 8-digit scanner. Scans N_DIG

---
 rtl/seven_seg_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed common-anode 7-segment scanner with double-buffered loads
//
// Scans N_DIG digits, one slot of CLK_DIV clocks per digit. Each slot begins with
// DEAD clocks of all anodes off to stop ghosting. Display data comes from an active
// buffer that only changes at a frame boundary, so a frame never mixes two loads.
//
// Optional feature: define SEVSEG_BRIGHTNESS_EN to turn on brightness control from
// `bright`. When it is not defined, `bright` is ignored and each digit is on for the
// whole slot after the dead time.
//
// Ports:
//   clk100MHZ   in   1        system clock, rising edge
//   rst_n       in   1        synchronous reset, active low
//   dig         in   4*N_DIG  hex nibble per digit, [3:0] = digit 0 (rightmost)
//   dp          in   N_DIG    decimal point per digit, 1 = lit
//   blank       in   N_DIG    force digit dark, 1 = dark
//   lz_en       in   1        leading-zero suppression enable
//   load        in   1        strobe: capture dig/dp/blank/lz_en into the pending buffer
//   bright      in   3        duty 0..7 (SEVSEG_BRIGHTNESS_EN only)
//   SEG         out  8        active-low segments, [0]=a .. [6]=g, [7]=dp
//   AN          out  N_DIG    active-low digit enables
//   frame_start out  1        one-cycle pulse as the digit 0 slot begins

module seven_seg_scanner #(
    parameter int N_DIG   = 8,
    parameter int CLK_DIV = 5000,
    parameter int DEAD    = 16
) (
    input  logic               clk100MHZ,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] dig,
    input  logic [N_DIG-1:0]   dp,
    input  logic [N_DIG-1:0]   blank,
    input  logic               lz_en,
    input  logic               load,
    input  logic [2:0]         bright,
    output logic [7:0]         SEG,
    output logic [N_DIG-1:0]   AN,
    output logic               frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(N_DIG);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DEAD_C   = DIV_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

    // Scan position
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Active (displayed) and pending buffers
    logic [4*N_DIG-1:0] act_dig_q, act_dig_d;
    logic [N_DIG-1:0]   act_dp_q, act_dp_d;
    logic [N_DIG-1:0]   act_blank_q, act_blank_d;
    logic               act_lz_q, act_lz_d;
    logic [4*N_DIG-1:0] pnd_dig_q, pnd_dig_d;
    logic [N_DIG-1:0]   pnd_dp_q, pnd_dp_d;
    logic [N_DIG-1:0]   pnd_blank_q, pnd_blank_d;
    logic               pnd_lz_q, pnd_lz_d;
    logic               pend_q, pend_d;

    // Registered outputs
    logic [7:0]         seg_q, seg_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               fs_q, fs_d;

    logic               tick;
    logic               boundary;
    logic               duty_on;
    logic [N_DIG-1:0]   supp;
    logic               upper_zero;
    logic [3:0]         cur_nib;
    logic               cur_dark;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick     = (div_cnt_q == DIV_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    // Slot timing
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef SEVSEG_BRIGHTNESS_EN
    localparam int LIM_W = DIV_W + 1;
    logic [2:0]       bright_q;
    logic [2:0]       bright_eff;
    logic [LIM_W-1:0] on_lim;

    // The value presented on the first cycle of a slot governs the whole slot.
    assign bright_eff = (div_cnt_q == '0) ? bright : bright_q;
    assign on_lim     = LIM_W'((int'(bright_eff) + 1) * (CLK_DIV / 8));
    assign duty_on    = ({1'b0, div_cnt_q} < on_lim);

    always_ff @(posedge clk100MHZ) begin
        if (!rst_n) begin
            bright_q <= '0;
        end else if (div_cnt_q == '0) begin
            bright_q <= bright;
        end
    end
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign duty_on       = 1'b1;
`endif

    // Buffer management: loads land in pending, pending moves to active only at the
    // frame boundary. A load on the boundary cycle bypasses pending so it is not lost.
    always_comb begin
        act_dig_d   = act_dig_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_lz_d    = act_lz_q;
        pnd_dig_d   = pnd_dig_q;
        pnd_dp_d    = pnd_dp_q;
        pnd_blank_d = pnd_blank_q;
        pnd_lz_d    = pnd_lz_q;
        pend_d      = pend_q;
        if (boundary) begin
            if (load) begin
                act_dig_d   = dig;
                act_dp_d    = dp;
                act_blank_d = blank;
                act_lz_d    = lz_en;
            end else if (pend_q) begin
                act_dig_d   = pnd_dig_q;
                act_dp_d    = pnd_dp_q;
                act_blank_d = pnd_blank_q;
                act_lz_d    = pnd_lz_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pnd_dig_d   = dig;
            pnd_dp_d    = dp;
            pnd_blank_d = blank;
            pnd_lz_d    = lz_en;
            pend_d      = 1'b1;
        end
    end

    // Leading-zero suppression: digit i>0 is dark when it and every digit above it is 0.
    always_comb begin
        supp       = '0;
        upper_zero = 1'b0;
        for (int i = 1; i < N_DIG; i++) begin
            upper_zero = 1'b1;
            for (int j = i; j < N_DIG; j++) begin
                if (act_dig_q[4*j +: 4] != 4'h0) begin
                    upper_zero = 1'b0;
                end
            end
            supp[i] = act_lz_q && upper_zero;
        end
    end

    // Output decode for the digit currently being scanned
    always_comb begin
        cur_nib  = act_dig_q[4*idx_q +: 4];
        cur_dark = act_blank_q[idx_q] || supp[idx_q];
        seg_d    = cur_dark ? 8'hFF : {~act_dp_q[idx_q], hex_to_seg(cur_nib)};
        an_d     = '1;
        if ((div_cnt_q >= DEAD_C) && duty_on) begin
            an_d[idx_q] = 1'b0;
        end
        fs_d = boundary;
    end

    always_ff @(posedge clk100MHZ) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            act_dig_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            act_lz_q    <= 1'b0;
            pnd_dig_q   <= '0;
            pnd_dp_q    <= '0;
            pnd_blank_q <= '0;
            pnd_lz_q    <= 1'b0;
            pend_q      <= 1'b0;
            seg_q       <= 8'hFF;
            an_q        <= '1;
            fs_q        <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            act_dig_q   <= act_dig_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            act_lz_q    <= act_lz_d;
            pnd_dig_q   <= pnd_dig_d;
            pnd_dp_q    <= pnd_dp_d;
            pnd_blank_q <= pnd_blank_d;
            pnd_lz_q    <= pnd_lz_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fs_q        <= fs_d;
        end
    end

    assign SEG         = seg_q;
    assign AN          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner

module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int CD = 16;
    localparam int DT = 2;
    localparam int FR = N * CD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4*N-1:0] dig;
    logic [N-1:0]  dp;
    logic [N-1:0]  blank;
    logic          lz_en;
    logic          load;
    logic [2:0]    bright;
    logic [7:0]    SEG;
    logic [N-1:0]  AN;
    logic          frame_start;

    always #5 clk = ~clk;

    seven_seg_scanner #(.N_DIG(N), .CLK_DIV(CD), .DEAD(DT)) dut (
        .clk100MHZ   (clk),
        .rst_n       (rst_n),
        .dig         (dig),
        .dp          (dp),
        .blank       (blank),
        .lz_en       (lz_en),
        .load        (load),
        .bright      (bright),
        .SEG         (SEG),
        .AN          (AN),
        .frame_start (frame_start)
    );

    logic [7:0] seg_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: what the display shows, and what is waiting to be shown
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_dp, p_dp, m_blank, p_blank;
    logic        m_lz, p_lz, m_pend;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int d);
        logic [15:0] above;
        logic [15:0] sh;
        logic [7:0]  s;
        above = m_dig >> (4 * d);
        sh    = above;
        if (m_blank[d]) return 8'hFF;
        if (m_lz && d > 0 && above == 16'h0) return 8'hFF;
        s = seg_tbl[sh[3:0]];
        if (m_dp[d]) s = s & 8'h7F;
        return s;
    endfunction

    task automatic model_reset();
        m_dig = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
        p_dig = '0; p_dp = '0; p_blank = '0; p_lz = 1'b0;
        m_pend = 1'b0;
        cyc = 0;
    endtask

    // One clock: expectations come from the scan position (cyc) before the edge and
    // the model buffers before the edge; then the load/commit rules update the model.
    task automatic step(input logic ld);
        int          s;
        int          d;
        logic [3:0]  ea;
        logic [7:0]  es;
        logic        ef;
        logic        bnd;
        s   = cyc;
        d   = (s / CD) % N;
        ea  = ((s % CD) < DT) ? 4'hF : ~(4'b0001 << d);
        es  = exp_seg(d);
        bnd = ((s % FR) == FR - 1);
        ef  = bnd;
        if (ld) begin
            if (bnd) begin
                m_dig = dig; m_dp = dp; m_blank = blank; m_lz = lz_en; m_pend = 1'b0;
            end else begin
                p_dig = dig; p_dp = dp; p_blank = blank; p_lz = lz_en; m_pend = 1'b1;
            end
        end else if (bnd && m_pend) begin
            m_dig = p_dig; m_dp = p_dp; m_blank = p_blank; m_lz = p_lz; m_pend = 1'b0;
        end
        load = ld;
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc++;
        chk("an", 32'(AN), 32'(ea));
        chk("seg", 32'(SEG), 32'(es));
        chk("frame_start", 32'(frame_start), 32'(ef));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic run_to(input int pos);
        while ((cyc % FR) != pos) step(1'b0);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_seg", 32'(SEG), 32'h0000_00FF);
            chk("rst_an", 32'(AN), 32'h0000_000F);
            chk("rst_fs", 32'(frame_start), 32'h0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                          input logic lz);
        dig = d; dp = p; blank = b; lz_en = lz;
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        bright = 3'd0;
        set_in(16'h0, 4'h0, 4'h0, 1'b0);
        model_reset();

        // Power-up reset, then a reset in the middle of a slot
        hold_reset(3);
        run(40);
        hold_reset(3);
        run(3 * FR);

        // Plain digits 1234
        set_in(16'h1234, 4'h0, 4'h0, 1'b0);
        step(1'b1);
        set_in(16'hFFFF, 4'hF, 4'h0, 1'b1);
        run(3 * FR);

        // Leading-zero suppression
        set_in(16'h0050, 4'h0, 4'h0, 1'b1);
        step(1'b1);
        run(2 * FR);
        set_in(16'h0000, 4'hF, 4'h0, 1'b1);
        step(1'b1);
        run(2 * FR);

        // Two loads in one frame: only the later one is shown
        run_to(20);
        set_in(16'hABCD, 4'h5, 4'h0, 1'b0);
        step(1'b1);
        run(5);
        set_in(16'h9876, 4'h2, 4'h0, 1'b0);
        step(1'b1);
        run(2 * FR);

        // Load on the boundary cycle goes straight into the next frame
        run_to(FR - 1);
        set_in(16'hE0F1, 4'h8, 4'h0, 1'b1);
        step(1'b1);
        run(FR + 8);

        // Blank and decimal point
        set_in(16'h4321, 4'b0001, 4'b0010, 1'b0);
        step(1'b1);
        run(2 * FR);

        // Random inputs every cycle, loads at random moments
        for (int i = 0; i < 1500; i++) begin
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            bright = 3'($urandom);
            step(($urandom % 20) == 0);
        end

        // Random load placed exactly on boundaries
        for (int i = 0; i < 4; i++) begin
            run_to(FR - 1);
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            step(1'b1);
        end
        run(FR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
